// File: rtl/video_pkg.sv
// Register map indices, bit positions and timing helpers for video_timing_gen.
// Pure constants and functions; no clocked logic.
package video_pkg;

    localparam logic [1:0] REG_STATUS   = 2'd0;
    localparam logic [1:0] REG_LINE_CMP = 2'd1;
    localparam logic [1:0] REG_IRQ      = 2'd2;
    localparam logic [1:0] REG_POS      = 2'd3;

    localparam int IRQ_EN_BIT      = 31;
    localparam int IRQ_PEND_BIT    = 0;
    localparam int STAT_ACTIVE_BIT = 16;
    localparam int STAT_VBLANK_BIT = 17;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// CPU register window bus between a host (master) and video_timing_gen (slave).
// Reads return one cycle after the address is presented; no backpressure.
interface video_timing_gen_if;
    logic [31:0] cpu_addr_in;
    logic [31:0] cpu_data_in;
    logic [3:0]  cpu_write_enable_in;
    logic [31:0] cpu_data_out;

    modport master (output cpu_addr_in, cpu_data_in, cpu_write_enable_in, input cpu_data_out);
    modport slave  (input cpu_addr_in, cpu_data_in, cpu_write_enable_in, output cpu_data_out);
endinterface

// File: rtl/video_delay_line.sv
// N-stage register delay for a W-bit bundle with a per-bit reset value.
// Latency N cycles (N=0 is a wire); always accepts, no backpressure.
module video_delay_line #(
    parameter int              W       = 4,
    parameter int              N       = 2,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);

    generate
        if (N == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_dat    = i_dat;
        end else begin : g_pipe
            logic [W-1:0] r_stage [N];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < N; i++) r_stage[i] <= RST_VAL;
                end else begin
                    r_stage[0] <= i_dat;
                    for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_dat = r_stage[N-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with delayed sync/active/new_frame and a CPU register window.
// Counters are undelayed; sync bundle lags by PIPE_DEPTH; reads are registered (1 cycle).
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter int SYNC_POL   = 1,
    parameter int PIPE_DEPTH = 2,
    localparam int H_TOTAL   = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL   = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic          clk_hdmi_in,
    input  logic          rst_in,
    output logic [HW-1:0] hcount_out,
    output logic [VW-1:0] vcount_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          active_draw_out,
    output logic          new_frame_out,
    output logic          irq_out,
    video_timing_gen_if.slave cpu
);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          SYNC_ON    = (SYNC_POL != 0);
    localparam logic [3:0]    RST_VEC    = {~SYNC_ON, ~SYNC_ON, 2'b00};

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_started;
    logic [15:0]   r_frame_count;
    logic [15:0]   r_line_cmp;
    logic          r_irq_en;
    logic          r_irq_pending;
    logic [31:0]   r_rdata;

    logic          w_active;
    logic          w_vblank;
    logic          w_hsync;
    logic          w_vsync;
    logic          w_new_frame;
    logic          w_line_match;
    logic [3:0]    w_raw;
    logic [3:0]    w_dly;
    logic [31:0]   w_rdata;
    logic [1:0]    w_idx;
    logic [3:0]    w_we;
    logic          w_unused;

    always_ff @(posedge clk_hdmi_in or posedge rst_in) begin
        if (rst_in) begin
            r_h       <= '0;
            r_v       <= '0;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    assign w_active    = (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign w_vblank    = (r_v >= V_ACT_C);
    assign w_hsync     = ((r_h >= HS_FIRST) && (r_h <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
    assign w_vsync     = ((r_v >= VS_FIRST) && (r_v <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
    // The (0,0) state held through reset is not a frame start.
    assign w_new_frame = r_started && (r_h == '0) && (r_v == '0);
    assign w_line_match = (r_h == '0) && (32'(r_v) == 32'(r_line_cmp));

    // Forcing the bundle during reset keeps a zero-depth pipe at its idle levels.
    assign w_raw = rst_in ? RST_VEC : {w_hsync, w_vsync, w_active, w_new_frame};

    video_delay_line #(
        .W       (4),
        .N       (PIPE_DEPTH),
        .RST_VAL (RST_VEC)
    ) u_delay (
        .i_clk (clk_hdmi_in),
        .i_rst (rst_in),
        .i_dat (w_raw),
        .o_dat (w_dly)
    );

    assign {hsync_out, vsync_out, active_draw_out, new_frame_out} = w_dly;
    assign hcount_out = r_h;
    assign vcount_out = r_v;
    assign irq_out    = r_irq_pending && r_irq_en;

    assign w_idx = cpu.cpu_addr_in[3:2];
    assign w_we  = cpu.cpu_write_enable_in;

    always_ff @(posedge clk_hdmi_in or posedge rst_in) begin
        if (rst_in) begin
            r_frame_count <= '0;
        end else if (w_new_frame) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    always_ff @(posedge clk_hdmi_in or posedge rst_in) begin
        if (rst_in) begin
            r_line_cmp <= '0;
            r_irq_en   <= 1'b0;
        end else if (w_idx == REG_LINE_CMP) begin
            if (w_we[0]) r_line_cmp[7:0]  <= cpu.cpu_data_in[7:0];
            if (w_we[1]) r_line_cmp[15:8] <= cpu.cpu_data_in[15:8];
            if (w_we[3]) r_irq_en         <= cpu.cpu_data_in[IRQ_EN_BIT];
        end
    end

    // A match in the same cycle as a clear keeps the interrupt pending.
    always_ff @(posedge clk_hdmi_in or posedge rst_in) begin
        if (rst_in) begin
            r_irq_pending <= 1'b0;
        end else if (w_line_match) begin
            r_irq_pending <= 1'b1;
        end else if ((w_idx == REG_IRQ) && w_we[0] && cpu.cpu_data_in[IRQ_PEND_BIT]) begin
            r_irq_pending <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            REG_STATUS: begin
                w_rdata[15:0]            = r_frame_count;
                w_rdata[STAT_ACTIVE_BIT] = w_active;
                w_rdata[STAT_VBLANK_BIT] = w_vblank;
            end
            REG_LINE_CMP: begin
                w_rdata[15:0]       = r_line_cmp;
                w_rdata[IRQ_EN_BIT] = r_irq_en;
            end
            REG_IRQ: w_rdata[IRQ_PEND_BIT] = r_irq_pending;
            REG_POS: w_rdata = {16'(r_v), 16'(r_h)};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_hdmi_in or posedge rst_in) begin
        if (rst_in) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign cpu.cpu_data_out = r_rdata;

    assign w_unused = ^{cpu.cpu_addr_in[31:4], cpu.cpu_addr_in[1:0], cpu.cpu_data_in[30:16], w_we[2]};

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 14x7 raster (98 cycles/frame).
// DUT a: SYNC_POL=1, PIPE_DEPTH=2; DUT b: SYNC_POL=0, PIPE_DEPTH=0.
module tb_video_timing_gen;

    localparam int HT    = 14;
    localparam int VT    = 7;
    localparam int FRAME = 98;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_timing_gen_if bus_a ();
    video_timing_gen_if bus_b ();

    logic [3:0] hc_a, hc_b;
    logic [2:0] vc_a, vc_b;
    logic hs_a, vs_a, act_a, nf_a, irq_a;
    logic hs_b, vs_b, act_b, nf_b, irq_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .PIPE_DEPTH(2)
    ) dut_a (
        .clk_hdmi_in(clk), .rst_in(rst),
        .hcount_out(hc_a), .vcount_out(vc_a),
        .hsync_out(hs_a), .vsync_out(vs_a),
        .active_draw_out(act_a), .new_frame_out(nf_a),
        .irq_out(irq_a), .cpu(bus_a)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0), .PIPE_DEPTH(0)
    ) dut_b (
        .clk_hdmi_in(clk), .rst_in(rst),
        .hcount_out(hc_b), .vcount_out(vc_b),
        .hsync_out(hs_b), .vsync_out(vs_b),
        .active_draw_out(act_b), .new_frame_out(nf_b),
        .irq_out(irq_b), .cpu(bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        bus_a.cpu_addr_in         = a;
        bus_a.cpu_data_in         = d;
        bus_a.cpu_write_enable_in = we;
        tick();
        bus_a.cpu_write_enable_in = 4'b0000;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus_a.cpu_addr_in         = a;
        bus_a.cpu_write_enable_in = 4'b0000;
        tick();
        d = bus_a.cpu_data_out;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < FRAME && (cyc % FRAME) != p; i++) tick();
    endtask

    function automatic logic [3:0] ref_h(input int c);
        return 4'(c % HT);
    endfunction

    function automatic logic [2:0] ref_v(input int c);
        return 3'((c / HT) % VT);
    endfunction

    function automatic logic ref_act(input int c);
        return (ref_h(c) < 4'd8) && (ref_v(c) < 3'd4);
    endfunction

    function automatic logic ref_hwin(input int c);
        return (ref_h(c) >= 4'd10) && (ref_h(c) <= 4'd11);
    endfunction

    // {hsync, vsync, active, new_frame} for the 2-deep, active-high instance.
    function automatic logic [3:0] exp_a(input int c);
        int p;
        if (c < 2) return 4'b0000;
        p = c - 2;
        return {ref_hwin(p), ref_v(p) == 3'd5, ref_act(p), (p > 0) && (p % FRAME == 0)};
    endfunction

    function automatic logic [3:0] exp_b(input int c);
        return {~ref_hwin(c), ref_v(c) != 3'd5, ref_act(c), (c > 0) && (c % FRAME == 0)};
    endfunction

    function automatic logic [31:0] exp_status(input int c);
        logic [31:0] s;
        s     = 32'(((c - 1) / FRAME) % 65536);
        s[16] = ref_act(c);
        s[17] = (ref_v(c) >= 3'd4);
        return s;
    endfunction

    function automatic logic [31:0] exp_pos(input int c);
        return {16'(ref_v(c)), 16'(ref_h(c))};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int n_act, n_nf, n_irq, c0;

        bus_a.cpu_addr_in = '0; bus_a.cpu_data_in = '0; bus_a.cpu_write_enable_in = '0;
        bus_b.cpu_addr_in = '0; bus_b.cpu_data_in = '0; bus_b.cpu_write_enable_in = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_pos_a", 32'({hc_a, vc_a}), 32'd0);
        chk("rst_out_a", 32'({hs_a, vs_a, act_a, nf_a, irq_a}), 32'd0);
        chk("rst_rd_a", bus_a.cpu_data_out, 32'd0);
        chk("rst_out_b", 32'({hs_b, vs_b, act_b, nf_b}), 32'b1100);

        // Release and walk three frames cycle by cycle.
        @(negedge clk);
        rst = 1'b0;
        #1;
        cyc = 0;
        n_act = 0;
        n_nf  = 0;
        for (int c = 0; c < 300; c++) begin
            chk($sformatf("t1_a c%0d", c), 32'({hc_a, vc_a, hs_a, vs_a, act_a, nf_a}),
                32'({ref_h(c), ref_v(c), exp_a(c)}));
            chk($sformatf("t2_b c%0d", c), 32'({hs_b, vs_b, act_b, nf_b}), 32'(exp_b(c)));
            n_act += int'(act_a);
            n_nf  += int'(nf_a);
            tick();
        end
        chk("t1_active_cnt", n_act, 32'd100);
        chk("t1_nf_cnt", n_nf, 32'd3);

        // cyc 300 is (6,0) after three frame starts.
        bus_rd(32'h0, rd);
        chk("t5_status", rd, 32'h0001_0003);
        bus_rd(32'hC, rd);
        chk("t5_pos", rd, 32'h0000_0007);

        bus_wr(32'h4, 32'h8000_0003, 4'hF);
        bus_wr(32'h8, 32'h1, 4'h1);
        chk("t3_cleared", 32'(irq_a), 32'd0);
        bus_rd(32'h4, rd);
        chk("t3_linecmp_rd", rd, 32'h8000_0003);
        wait_pos(42);
        chk("t3_at_match", 32'(irq_a), 32'd0);
        tick();
        chk("t3_rise", 32'(irq_a), 32'd1);
        bus_rd(32'h8, rd);
        chk("t3_irq_rd", rd, 32'h1);
        bus_wr(32'h8, 32'h1, 4'h1);
        chk("t3_w1c", 32'(irq_a), 32'd0);
        wait_pos(42);
        bus_wr(32'h8, 32'h1, 4'h1);
        chk("t3_set_wins", 32'(irq_a), 32'd1);
        bus_wr(32'h8, 32'h1, 4'h1);
        chk("t3_w1c_again", 32'(irq_a), 32'd0);

        bus_wr(32'h4, 32'h8000_0009, 4'hF);
        n_irq = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            n_irq += int'(irq_a);
            tick();
        end
        chk("t4_no_irq", n_irq, 32'd0);
        bus_wr(32'h4, 32'h0000_00FF, 4'b0001);
        bus_rd(32'h4, rd);
        chk("t4_strobe", rd, 32'h8000_00FF);

        bus_wr(32'h0, 32'hFFFF_FFFF, 4'hF);
        bus_wr(32'hC, 32'hFFFF_FFFF, 4'hF);
        c0 = cyc;
        bus_rd(32'h0, rd);
        chk("t5_status_ro", rd, exp_status(c0));
        c0 = cyc;
        bus_rd(32'hC, rd);
        chk("t5_pos_ro", rd, exp_pos(c0));

        wait_pos(50);
        force dut_a.r_frame_count = 16'hFFFF;
        tick();
        release dut_a.r_frame_count;
        bus_rd(32'h0, rd);
        chk("t5_forced", 32'(rd[15:0]), 32'h0000_FFFF);
        wait_pos(5);
        bus_rd(32'h0, rd);
        chk("t5_wrap", 32'(rd[15:0]), 32'h0000_0000);

        // Arm a compare on line 1 so irq is high going into the reset.
        wait_pos(0);
        bus_wr(32'h4, 32'h8000_0001, 4'hF);
        wait_pos(20);
        chk("t6_irq_pre", 32'(irq_a), 32'd1);
        bus_rd(32'hC, rd);
        wait_pos(33);
        chk("t6_pos_pre", 32'({hc_a, vc_a}), 32'({4'd5, 3'd2}));
        rst = 1'b1;
        #1;
        chk("t6_pos_a", 32'({hc_a, vc_a}), 32'd0);
        chk("t6_out_a", 32'({hs_a, vs_a, act_a, nf_a, irq_a}), 32'd0);
        chk("t6_rd_a", bus_a.cpu_data_out, 32'd0);
        chk("t6_out_b", 32'({hs_b, vs_b, act_b, nf_b}), 32'b1100);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cyc  = 0;
        n_nf = 0;
        for (int c = 0; c < 110; c++) begin
            chk($sformatf("t6_a c%0d", c), 32'({hc_a, vc_a, hs_a, vs_a, act_a, nf_a}),
                32'({ref_h(c), ref_v(c), exp_a(c)}));
            chk($sformatf("t6_b c%0d", c), 32'({hs_b, vs_b, act_b, nf_b}), 32'(exp_b(c)));
            n_nf += int'(nf_a);
            tick();
        end
        chk("t6_nf_cnt", n_nf, 32'd1);
        bus_rd(32'h4, rd);
        chk("t6_linecmp_rst", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
